signed_bcd_ctrl: RTL and testbench

SIGNED_BCD_CTRL -- requirements
Module: signed_bcd_ctrl

---
 rtl/signed_bcd_pkg.sv | 21 ++
 rtl/signed_bcd_ctrl_if.sv | 33 +++
 rtl/signed_bcd_ctrl_add3.sv | 18 +
 rtl/signed_bcd_ctrl.sv | 143 ++++++++++++++
 tb/tb_signed_bcd_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/signed_bcd_pkg.sv
// Shared types and constants for the signed 8-bit to 3-digit BCD converter.
// Optional build macro: LEADING_ZERO_BLANK_EN (leading-zero blanking mask).
package signed_bcd_pkg;

  // Number of shift/add-3 iterations, one per magnitude bit.
  localparam int N_ITER  = 8;
  // Width of one BCD digit.
  localparam int DIGIT_W = 4;
  // Iteration counter width; holds 0..N_ITER-1.
  localparam int CNT_W   = 4;
  // Counter value during the final shift cycle.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_ITER - 1);

  // Controller states. SHIFT covers the whole conversion.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/signed_bcd_ctrl_if.sv
// Request/result bundle for signed_bcd_ctrl.
//
// Handshake: start is a request that the block accepts only while it is
// idle (busy=0, done=0, rst=0); din is sampled on the accepting edge only.
// A start seen at any other time is dropped, never queued. done is a
// one-cycle pulse; sign/hundreds/tens/ones/blank are valid from that cycle
// and hold until the next done.
interface signed_bcd_ctrl_if;
  import signed_bcd_pkg::*;

  logic               start;
  logic [7:0]         din;
  logic               busy;
  logic               done;
  logic               sign;
  logic [DIGIT_W-1:0] hundreds;
  logic [DIGIT_W-1:0] tens;
  logic [DIGIT_W-1:0] ones;
  logic [2:0]         blank;

  // Requester side (drives start/din, observes results).
  modport master (
    output start, din,
    input  busy, done, sign, hundreds, tens, ones, blank
  );

  // Converter side.
  modport slave (
    input  start, din,
    output busy, done, sign, hundreds, tens, ones, blank
  );

endinterface

// File: rtl/signed_bcd_ctrl_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more so
// that the following left shift carries correctly into the next digit.
module add3
  import signed_bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  // Pure combinational correction.
  always_comb begin
    dout = din;
    if (din >= DIGIT_W'(5)) begin
      dout = din + DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/signed_bcd_ctrl.sv
// signed_bcd_ctrl: converts an 8-bit two's-complement sample into a sign bit
// and three BCD digits of its magnitude using an 8-cycle double-dabble.
// Build macro LEADING_ZERO_BLANK_EN enables the leading-zero blank mask;
// without it, blank is tied to 3'b000.
module signed_bcd_ctrl
  import signed_bcd_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  signed_bcd_ctrl_if.slave   bus,
  output state_e             dbg_state
);

  state_e               state_q;
  state_e               state_d;

  // Working registers for the conversion in flight.
  logic                 sign_lat_q;
  logic [7:0]           mag_q;
  logic [3*DIGIT_W-1:0] scratch_q;
  logic [CNT_W-1:0]     cnt_q;

  // Result registers, updated only when a conversion completes.
  logic                 sign_q;
  logic [DIGIT_W-1:0]   hund_q;
  logic [DIGIT_W-1:0]   tens_q;
  logic [DIGIT_W-1:0]   ones_q;
  logic [2:0]           blank_q;

  // Corrected digits and the shifted scratch/magnitude pair.
  logic [DIGIT_W-1:0]   corr_h;
  logic [DIGIT_W-1:0]   corr_t;
  logic [DIGIT_W-1:0]   corr_o;
  logic [3*DIGIT_W+7:0] shifted;
  logic [3*DIGIT_W-1:0] scratch_nxt;
  logic [7:0]           mag_nxt;
  logic [2:0]           blank_nxt;
  logic [7:0]           din_mag;
  logic                 accept;
  logic                 last_shift;

  add3 u_add3_h (.din(scratch_q[3*DIGIT_W-1:2*DIGIT_W]), .dout(corr_h));
  add3 u_add3_t (.din(scratch_q[2*DIGIT_W-1:DIGIT_W]),   .dout(corr_t));
  add3 u_add3_o (.din(scratch_q[DIGIT_W-1:0]),           .dout(corr_o));

  // Correct first, then shift the whole {scratch, magnitude} pair left by one.
  always_comb begin
    shifted     = {corr_h, corr_t, corr_o, mag_q} << 1;
    scratch_nxt = shifted[3*DIGIT_W+7:8];
    mag_nxt     = shifted[7:0];
  end

  // Magnitude of the incoming sample; 8'h80 maps to 128 in 8 unsigned bits.
  always_comb begin
    din_mag = bus.din;
    if (bus.din[7]) begin
      din_mag = ~bus.din + 8'd1;
    end
  end

  // Blank mask for the digits about to be published.
  always_comb begin
    blank_nxt = 3'b000;
`ifdef LEADING_ZERO_BLANK_EN
    blank_nxt[2] = (scratch_nxt[3*DIGIT_W-1:2*DIGIT_W] == '0);
    blank_nxt[1] = (scratch_nxt[3*DIGIT_W-1:2*DIGIT_W] == '0) &&
                   (scratch_nxt[2*DIGIT_W-1:DIGIT_W] == '0);
    blank_nxt[0] = 1'b0;
`endif
  end

  assign accept     = (state_q == IDLE) && bus.start;
  assign last_shift = (state_q == SHIFT) && (cnt_q == LAST_CNT);

  // Next-state logic: IDLE -> SHIFT on start, 8 shifts, one DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset wins over a coincident start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Conversion datapath: load on accept, shift while in SHIFT.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_lat_q <= 1'b0;
      mag_q      <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
    end else if (accept) begin
      sign_lat_q <= bus.din[7];
      mag_q      <= din_mag;
      scratch_q  <= '0;
      cnt_q      <= '0;
    end else if (state_q == SHIFT) begin
      mag_q      <= mag_nxt;
      scratch_q  <= scratch_nxt;
      cnt_q      <= cnt_q + CNT_W'(1);
    end
  end

  // Result registers: published on the edge of the final shift, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q  <= 1'b0;
      hund_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      blank_q <= 3'b000;
    end else if (last_shift) begin
      sign_q  <= sign_lat_q;
      hund_q  <= scratch_nxt[3*DIGIT_W-1:2*DIGIT_W];
      tens_q  <= scratch_nxt[2*DIGIT_W-1:DIGIT_W];
      ones_q  <= scratch_nxt[DIGIT_W-1:0];
      blank_q <= blank_nxt;
    end
  end

  // Status and result outputs.
  always_comb begin
    bus.busy     = (state_q == SHIFT);
    bus.done     = (state_q == DONE);
    bus.sign     = sign_q;
    bus.hundreds = hund_q;
    bus.tens     = tens_q;
    bus.ones     = ones_q;
    bus.blank    = blank_q;
    dbg_state    = state_q;
  end

endmodule

// File: tb/tb_signed_bcd_ctrl.sv
// Self-checking bench for signed_bcd_ctrl: table of signed samples with
// hand-derived digits, random samples against an arithmetic model, and
// hand-written sequences for start-during-SHIFT and reset-abort.
module tb_signed_bcd_ctrl;
  import signed_bcd_pkg::*;

  localparam int W = 16;   // {sign, hundreds, tens, ones, blank}

  logic   clk;
  logic   rst;
  state_e dbg_state;

  signed_bcd_ctrl_if bus ();

  signed_bcd_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int tests;
  int fails;

  typedef struct {
    logic [7:0] din;
    logic       s;
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
  } vec_t;

  function automatic logic [2:0] exp_blank(logic [3:0] h, logic [3:0] t);
    logic [2:0] b;
    b = 3'b000;
`ifdef LEADING_ZERO_BLANK_EN
    b[2] = (h == 4'd0);
    b[1] = (h == 4'd0) && (t == 4'd0);
`endif
    return b;
  endfunction

  function automatic logic [W-1:0] pack(logic s, logic [3:0] h, logic [3:0] t, logic [3:0] o);
    return {s, h, t, o, exp_blank(h, t)};
  endfunction

  // Arithmetic reference: magnitude by integer negation, digits by division.
  function automatic logic [W-1:0] model(logic [7:0] d);
    int m;
    m = d[7] ? (256 - int'(d)) : int'(d);
    return pack(d[7], 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10));
  endfunction

  function automatic logic [W-1:0] observed();
    return {bus.sign, bus.hundreds, bus.tens, bus.ones, bus.blank};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Issues one start with din=d; after the accepting edge drives start=hold
  // and din=alt through the conversion. Checks latency, busy width, results.
  task automatic convert(input string name, input logic [7:0] d, input logic [W-1:0] exp,
                         input logic hold, input logic [7:0] alt);
    int lat;
    int busy_n;
    logic got;
    logic [W-1:0] e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.din   = d;
    exp_q.push_back(exp);
    lat    = 0;
    busy_n = 0;
    got    = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (i == 0) begin
        bus.start = hold;
        bus.din   = alt;
      end
      if (bus.busy) busy_n++;
      if (bus.done) got = 1'b1;
    end
    bus.start = 1'b0;
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: no done within 20 cycles", name);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      check({name, " result"}, observed(), e);
      check({name, " latency"}, W'(lat), W'(9));
      check({name, " busy cycles"}, W'(busy_n), W'(8));
      @(negedge clk);
      check({name, " done pulse/hold"}, {bus.done, bus.busy, observed()} , {2'b00, e});
    end
  endtask

  vec_t vecs[8];

  initial begin
    tests = 0;
    fails = 0;
    rst       = 1'b1;
    bus.start = 1'b1;  // start coincident with reset must be ignored
    bus.din   = 8'h55;
    repeat (3) @(negedge clk);
    check("reset state", {12'(dbg_state), bus.busy, bus.done, 2'b00}, 16'h0000);
    check("reset outputs", observed(), '0);
    bus.start = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    check("idle after reset", {14'(dbg_state), bus.busy, bus.done}, 16'h0000);

    vecs[0] = '{8'h7F, 1'b0, 4'd1, 4'd2, 4'd7};
    vecs[1] = '{8'h80, 1'b1, 4'd1, 4'd2, 4'd8};
    vecs[2] = '{8'hFF, 1'b1, 4'd0, 4'd0, 4'd1};
    vecs[3] = '{8'h00, 1'b0, 4'd0, 4'd0, 4'd0};
    vecs[4] = '{8'h2A, 1'b0, 4'd0, 4'd4, 4'd2};
    vecs[5] = '{8'h64, 1'b0, 4'd1, 4'd0, 4'd0};
    vecs[6] = '{8'hF6, 1'b1, 4'd0, 4'd1, 4'd0};
    vecs[7] = '{8'h63, 1'b0, 4'd0, 4'd9, 4'd9};

    foreach (vecs[i]) begin
      convert($sformatf("vec%0d din=%h", i, vecs[i].din), vecs[i].din,
              pack(vecs[i].s, vecs[i].h, vecs[i].t, vecs[i].o), 1'b0, 8'h00);
    end

    // Random samples; din is scrambled during SHIFT to prove it is not re-sampled.
    for (int k = 0; k < 12; k++) begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      convert($sformatf("rand%0d din=%h", k, d), d, model(d), 1'b0, 8'($urandom_range(0, 255)));
    end

    // Start held high with a new din during SHIFT: single result, no requeue.
    convert("held start 9C", 8'h9C, pack(1'b1, 4'd1, 4'd0, 4'd0), 1'b1, 8'h05);
    begin
      int extra;
      extra = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (bus.busy || bus.done) extra++;
      end
      check("no second conversion", W'(extra), W'(0));
      check("held start outputs kept", observed(), pack(1'b1, 4'd1, 4'd0, 4'd0));
    end

    // Reset in cycle N+4 of a conversion: abort, no done, outputs cleared.
    begin
      int seen;
      @(negedge clk);
      bus.start = 1'b1;
      bus.din   = 8'h2A;
      @(negedge clk);            // cycle N+1
      bus.start = 1'b0;
      @(negedge clk);            // N+2
      @(negedge clk);            // N+3
      @(negedge clk);            // N+4
      check("busy before abort", W'(bus.busy), W'(1));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (bus.done || bus.busy) seen++;
      end
      check("abort no done", W'(seen), W'(0));
      check("abort outputs zero", observed(), '0);
      check("abort state idle", W'(dbg_state), W'(IDLE));
    end
    convert("after abort 2A", 8'h2A, pack(1'b0, 4'd0, 4'd4, 4'd2), 1'b0, 8'h00);

    check("scoreboard drained", W'(exp_q.size()), W'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
